// File: rtl/bit_serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Holds the FSM state encoding and the counter-width function.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
// master issues operands and start; slave returns status and result.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// Combinational 1-bit full adder, the single arithmetic cell of the
// serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/bit_serial_adder.sv
// Streams two WIDTH-bit operands LSB-first through one full-adder cell,
// one bit per clock, and publishes sum/cout/ovf when the MSB completes.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  bit_serial_adder_if.slave bus
);
  localparam int CW = clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit, last_bit, load;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r, ovf_r;

  fa_cell u_fa (
    .x (sa[0]),
    .y (sb[0]),
    .ci(carry),
    .s (s_bit),
    .co(c_bit)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_nxt = s_bit;
    end else begin : g_accn
      assign acc_nxt = {s_bit, acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE accepts start like IDLE so back-to-back requests lose no cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (load) begin
      sa    <= bus.a;
      sb    <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == SHIFT) begin
      acc   <= acc_nxt;
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= c_bit;
      cnt   <= cnt + CW'(1);
      // carry still holds the carry into the MSB on this edge
      if (last_bit) begin
        sum_r  <= acc_nxt;
        cout_r <= c_bit;
        ovf_r  <= carry ^ c_bit;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
